// File: rtl/dlx_pkg.sv
// Shared types and constants for the DLX instruction-fetch front end.
package dlx_pkg;
  localparam int DLX_XLEN = 32;
  localparam int INSTR_W  = 32;

  typedef enum logic {
    SETTLE = 1'b0,
    FETCH  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [DLX_XLEN-1:0] pc;
    logic [INSTR_W-1:0]  instr;
  } fetch_entry_t;
endpackage

// File: rtl/dlx_sync_fifo.sv
// Synchronous FIFO with flush; a push is accepted while full when a pop happens the same cycle.
module dlx_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_n || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/dlx_fetch_queue.sv
// Instruction-fetch front end: fetch PC register, SETTLE/FETCH control and a decoupling queue
// presenting {pc, instr} to decode over valid/ready.
module dlx_fetch_queue
  import dlx_pkg::*;
#(
  parameter int              XLEN     = DLX_XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   fetch_en,
  output logic [XLEN-1:0]        i_address,
  input  logic [INSTR_W-1:0]     i_data_read,
  input  logic                   i_data_valid,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [INSTR_W-1:0]     dec_instr,
  output logic [XLEN-1:0]        dec_pc,
  output logic [$clog2(DEPTH):0] occupancy,
  output fetch_state_t           dbg_state_o
);
  localparam int EW = XLEN + INSTR_W;

  // Handshake: a word moves to decode on a cycle where dec_valid and dec_ready are both high;
  // dec_valid never depends on dec_ready, and the head stays stable until consumed.
  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [EW-1:0]   head;
  logic            full, empty, push, pop;

  assign dec_valid = ~empty;
  assign pop       = dec_valid & dec_ready;
  assign push      = (state_q == FETCH) & fetch_en & i_data_valid & ~redirect_valid
                     & (~full | pop);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      SETTLE:  state_d = FETCH;
      FETCH:   state_d = FETCH;
      default: state_d = SETTLE;
    endcase
    if (redirect_valid) begin
      state_d = SETTLE;
      pc_d    = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};
    end else if (push) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= SETTLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  dlx_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (redirect_valid),
    .push_i  (push),
    .data_i  ({pc_q, i_data_read}),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (occupancy),
    .full_o  (full),
    .empty_o (empty)
  );

  // Outputs read as zero whenever the queue is empty, so stale storage is never exposed.
  assign i_address   = pc_q;
  assign dec_pc      = dec_valid ? head[EW-1:INSTR_W] : '0;
  assign dec_instr   = dec_valid ? head[INSTR_W-1:0] : '0;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_dlx_fetch_queue.sv
// Bench for dlx_fetch_queue: combinational ROM model, queue-based reference scoreboard and
// directed scenario checks.
`timescale 1ns/1ps
module tb_dlx_fetch_queue;
  import dlx_pkg::*;

  localparam int              DEPTH    = 4;
  localparam int              OW       = $clog2(DEPTH) + 1;
  localparam logic [31:0]     RESET_PC = 32'h0;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              fetch_en = 1'b0;
  logic              i_data_valid = 1'b0;
  logic              redirect_valid = 1'b0;
  logic              dec_ready = 1'b0;
  logic [31:0]       redirect_pc = '0;
  logic [31:0]       i_address, i_data_read, dec_instr, dec_pc;
  logic              dec_valid;
  logic [OW-1:0]     occupancy;
  fetch_state_t      dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_entry_t exp_q[$];
  logic [31:0]  exp_pc = RESET_PC;
  bit           exp_settle = 1'b1;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign i_data_read = rom_word(i_address);

  dlx_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fetch_en       (fetch_en),
    .i_address      (i_address),
    .i_data_read    (i_data_read),
    .i_data_valid   (i_data_valid),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .occupancy      (occupancy),
    .dbg_state_o    (dbg_state)
  );

  // One clock of stimulus: drive at negedge, advance the reference at posedge, score at negedge.
  task automatic run_cycle(input bit rst_n, input bit fe, input bit dv, input bit rdy,
                           input bit rv, input logic [31:0] rpc);
    bit pop, push;
    reset_n = rst_n; fetch_en = fe; i_data_valid = dv; dec_ready = rdy;
    redirect_valid = rv; redirect_pc = rpc;
    pop  = (exp_q.size() != 0) && rdy;
    push = rst_n && !rv && !exp_settle && fe && dv && ((exp_q.size() < DEPTH) || pop);
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete(); exp_pc = RESET_PC; exp_settle = 1'b1;
    end else if (rv) begin
      exp_q.delete(); exp_pc = {rpc[31:2], 2'b00}; exp_settle = 1'b1;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        exp_q.push_back('{pc: exp_pc, instr: rom_word(exp_pc)});
        exp_pc = exp_pc + 32'd4;
      end
      exp_settle = 1'b0;
    end
    @(negedge clk);
    n_cmp++;
    if (dec_valid !== (exp_q.size() != 0)) begin
      n_fail++; $display("FAIL sb_dec_valid: got %b want %b", dec_valid, exp_q.size() != 0);
    end
    n_cmp++;
    if (occupancy !== OW'(exp_q.size())) begin
      n_fail++; $display("FAIL sb_occupancy: got %0d want %0d", occupancy, exp_q.size());
    end
    n_cmp++;
    if (i_address !== exp_pc) begin
      n_fail++; $display("FAIL sb_i_address: got %h want %h", i_address, exp_pc);
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      if (dec_pc !== exp_q[0].pc || dec_instr !== exp_q[0].instr) begin
        n_fail++;
        $display("FAIL sb_head: got pc=%h instr=%h want pc=%h instr=%h",
                 dec_pc, dec_instr, exp_q[0].pc, exp_q[0].instr);
      end
    end
  endtask

  task automatic test_reset();
    run_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0444);
    run_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (i_address !== RESET_PC || occupancy !== '0 || dec_valid !== 1'b0 ||
        dec_pc !== 32'h0 || dec_instr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_values: got addr=%h occ=%0d v=%b pc=%h instr=%h want %h,0,0,0,0",
               i_address, occupancy, dec_valid, dec_pc, dec_instr, RESET_PC);
    end
    n_cmp++;
    if (dbg_state !== SETTLE) begin
      n_fail++; $display("FAIL reset_state: got %0d want SETTLE", dbg_state);
    end
    run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (dbg_state !== FETCH || occupancy !== '0) begin
      n_fail++; $display("FAIL settle_exit: got state=%0d occ=%0d want FETCH,0", dbg_state, occupancy);
    end
  endtask

  task automatic test_stream();
    run_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (i >= 1) begin
        n_cmp++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'(4 * (i - 1))) begin
          n_fail++; $display("FAIL stream_pc: got v=%b pc=%h want 1,%h", dec_valid, dec_pc, 4 * (i - 1));
        end
      end
    end
  endtask

  task automatic test_full_drain();
    logic [31:0] seen[$];
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (occupancy !== OW'(DEPTH) || i_address !== 32'h10) begin
      n_fail++; $display("FAIL full_hold: got occ=%0d addr=%h want %0d,00000010", occupancy, i_address, DEPTH);
    end
    for (int i = 0; i < 8; i++) begin
      if (dec_valid) seen.push_back(dec_pc);
      run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (seen.size() <= i) begin
        n_fail++; $display("FAIL drain_order[%0d]: got nothing want %h", i, 4 * i);
      end else if (seen[i] !== 32'(4 * i)) begin
        n_fail++; $display("FAIL drain_order[%0d]: got %h want %h", i, seen[i], 4 * i);
      end
    end
  endtask

  task automatic test_redirect();
    bit found = 1'b0;
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (occupancy !== OW'(3)) begin
      n_fail++; $display("FAIL redirect_pre_occ: got %0d want 3", occupancy);
    end
    run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0103);
    n_cmp++;
    if (occupancy !== '0 || dec_valid !== 1'b0 || i_address !== 32'h100 || dbg_state !== SETTLE) begin
      n_fail++;
      $display("FAIL redirect_flush: got occ=%0d v=%b addr=%h st=%0d want 0,0,00000100,SETTLE",
               occupancy, dec_valid, i_address, dbg_state);
    end
    run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (occupancy !== '0 || i_address !== 32'h100) begin
      n_fail++; $display("FAIL settle_drop: got occ=%0d addr=%h want 0,00000100", occupancy, i_address);
    end
    for (int i = 0; i < 6 && !found; i++) begin
      run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (dec_valid) begin
        found = 1'b1;
        n_cmp++;
        if (dec_pc !== 32'h100) begin
          n_fail++; $display("FAIL redirect_first_pc: got %h want 00000100", dec_pc);
        end
      end
    end
    if (!found) begin
      n_cmp++; n_fail++; $display("FAIL redirect_first_pc: got timeout want 00000100");
    end
  endtask

  task automatic test_full_push_pop();
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (occupancy !== OW'(DEPTH) || dec_pc !== 32'(4 * (i + 1))) begin
        n_fail++; $display("FAIL full_pushpop: got occ=%0d pc=%h want %0d,%h", occupancy, dec_pc, DEPTH, 4 * (i + 1));
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] seen[$];
    run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 6; i++) begin
      if (dec_valid) seen.push_back(dec_pc);
      run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    end
    n_cmp++;
    if (seen.size() < 2) begin
      n_fail++; $display("FAIL wrap_pcs: got %0d words want 2+", seen.size());
    end else if (seen[0] !== 32'hFFFF_FFFC || seen[1] !== 32'h0) begin
      n_fail++; $display("FAIL wrap_pcs: got %h,%h want fffffffc,00000000", seen[0], seen[1]);
    end
  endtask

  task automatic test_random();
    bit          fe = 1'b1;
    bit          rv;
    logic [31:0] rpc;
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) fe = ~fe;
      rv  = ($urandom_range(0, 39) == 0);
      rpc = $urandom;
      if (c == 200) begin
        run_cycle(1'b0, fe, 1'b1, 1'b1, rv, rpc);
        n_cmp++;
        if (occupancy !== '0 || dec_valid !== 1'b0 || i_address !== RESET_PC ||
            dec_pc !== 32'h0 || dec_instr !== 32'h0) begin
          n_fail++;
          $display("FAIL midstream_reset: got occ=%0d v=%b addr=%h pc=%h instr=%h want 0,0,%h,0,0",
                   occupancy, dec_valid, i_address, dec_pc, dec_instr, RESET_PC);
        end
      end else begin
        run_cycle(1'b1, fe, (c % 3) == 0, $urandom_range(0, 1) == 1, rv, rpc);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_full_drain();
    test_redirect();
    test_full_push_pop();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
